// File: rtl/hwpe_stream_fifo_scm_ctrl.sv
// Stream FIFO controller around a latch-based SCM with a 1-cycle registered read port.
// Owns the pointers, the occupancy count and the head-of-queue state; the SCM holds the data.
module hwpe_stream_fifo_scm_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ALMOST_FULL_TH = 2**ADDR_WIDTH-2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  mem_re_o,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [ADDR_WIDTH:0]   occupancy_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o
);

    localparam int unsigned         DEPTH     = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_OCC = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_OCC    = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);

    typedef enum logic {
        NO_HEAD = 1'b0,
        HEAD    = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;

    logic                  head;
    logic                  push_fire;
    logic                  pop_fire;
    logic                  fetch;
    logic [ADDR_WIDTH:0]   fetchable;

    always_comb begin
        head         = (state_q == HEAD);
        // Entries sitting in the SCM that have not been moved to the head yet.
        fetchable    = occ_q - {{ADDR_WIDTH{1'b0}}, head};
        push_ready_o = (occ_q < DEPTH_OCC) & ~clear_i;
        push_fire    = push_valid_i & push_ready_o;
        pop_valid_o  = head;
        pop_fire     = head & pop_ready_i;

        fetch   = 1'b0;
        state_d = state_q;
        if (!clear_i) begin
            case (state_q)
                NO_HEAD: begin
                    if (fetchable != '0) begin
                        fetch   = 1'b1;
                        state_d = HEAD;
                    end
                end
                HEAD: begin
                    if (pop_fire) begin
                        if (fetchable != '0) begin
                            fetch = 1'b1;
                        end else begin
                            state_d = NO_HEAD;
                        end
                    end
                end
                default: state_d = NO_HEAD;
            endcase
        end

        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            occ_d   = '0;
            state_d = NO_HEAD;
        end else begin
            wptr_d = wptr_q + {{(ADDR_WIDTH-1){1'b0}}, push_fire};
            rptr_d = rptr_q + {{(ADDR_WIDTH-1){1'b0}}, fetch};
            occ_d  = occ_q + {{ADDR_WIDTH{1'b0}}, push_fire} - {{ADDR_WIDTH{1'b0}}, pop_fire};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NO_HEAD;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
        end
    end

    // Strobes are forced low during reset so the SCM is never touched while held in reset.
    assign mem_we_o      = push_fire & rst_n;
    assign mem_waddr_o   = wptr_q;
    assign mem_wdata_o   = push_data_i;
    assign mem_re_o      = fetch & rst_n;
    assign mem_raddr_o   = rptr_q;
    assign pop_data_o    = mem_rdata_i;

    assign occupancy_o   = occ_q;
    assign empty_o       = (occ_q == '0);
    assign full_o        = (occ_q == DEPTH_OCC);
    assign almost_full_o = (occ_q >= AF_OCC);

endmodule

// File: tb/tb_hwpe_stream_fifo_scm_ctrl.sv
// Bench for hwpe_stream_fifo_scm_ctrl with a 4-entry SCM; a queue model predicts
// the stream behaviour and every memory strobe from the FIFO rules and latency.
module tb_hwpe_stream_fifo_scm_ctrl;

    localparam int AW  = 2;
    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int AFT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_i = 1'b0;
    logic          push_valid_i = 1'b0;
    logic          push_ready_o;
    logic [DW-1:0] push_data_i = '0;
    logic          pop_valid_o;
    logic          pop_ready_i = 1'b0;
    logic [DW-1:0] pop_data_o;
    logic          mem_re_o;
    logic [AW-1:0] mem_raddr_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_waddr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [AW:0]   occupancy_o;
    logic          empty_o;
    logic          full_o;
    logic          almost_full_o;

    hwpe_stream_fifo_scm_ctrl #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .ALMOST_FULL_TH(AFT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (clear_i),
        .push_valid_i (push_valid_i),
        .push_ready_o (push_ready_o),
        .push_data_i  (push_data_i),
        .pop_valid_o  (pop_valid_o),
        .pop_ready_i  (pop_ready_i),
        .pop_data_o   (pop_data_o),
        .mem_re_o     (mem_re_o),
        .mem_raddr_o  (mem_raddr_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_we_o     (mem_we_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .occupancy_o  (occupancy_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .almost_full_o(almost_full_o)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // SCM: write sampled at clk, registered read
    logic [DW-1:0] scm_mem [DEP];
    always @(posedge clk) begin
        if (mem_we_o) scm_mem[mem_waddr_o] <= mem_wdata_o;
        if (mem_re_o) mem_rdata_i <= scm_mem[mem_raddr_o];
    end

    // Scoreboard: data, push cycle and SCM slot of every accepted entry
    logic [DW-1:0] exp_q[$];
    int            pc_q[$];
    int            idx_q[$];
    int            wcnt;
    int            last_pop;
    int            t;
    int            n_vec;
    int            n_err;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pc_q.delete();
        idx_q.delete();
        wcnt     = 0;
        last_pop = -100;
    endtask

    function automatic int ready_time(input int pc);
        return (pc + 2 > last_pop + 1) ? pc + 2 : last_pop + 1;
    endfunction

    // One clock cycle: drive, check at negedge against the model, advance the model.
    task automatic step(input logic pv, input logic [DW-1:0] pd, input logic pr, input logic clr,
                        output logic accepted);
        logic exp_valid, exp_ready, push_fire, pop_fire, exp_re;
        int   occ, cand, exp_raddr, nxt_pop;
        push_valid_i = pv;
        push_data_i  = pd;
        pop_ready_i  = pr;
        clear_i      = clr;
        @(negedge clk);
        occ       = exp_q.size();
        exp_valid = (occ > 0) && (t >= ready_time(pc_q[0]));
        exp_ready = (occ < DEP) && !clr;
        push_fire = pv && exp_ready;
        pop_fire  = exp_valid && pr;

        // The entry that heads the queue next cycle is fetched now if it is due exactly then.
        exp_re    = 1'b0;
        exp_raddr = 0;
        cand      = pop_fire ? 1 : (exp_valid ? -1 : 0);
        nxt_pop   = pop_fire ? t : last_pop;
        if (!clr && cand >= 0 && cand < occ) begin
            if (((pc_q[cand] + 2 > nxt_pop + 1) ? pc_q[cand] + 2 : nxt_pop + 1) == t + 1) begin
                exp_re    = 1'b1;
                exp_raddr = idx_q[cand];
            end
        end

        check_eq("pop_valid", pop_valid_o, exp_valid);
        if (exp_valid) check_eq("pop_data", pop_data_o, exp_q[0]);
        check_eq("push_ready", push_ready_o, exp_ready);
        check_eq("occupancy", occupancy_o, occ);
        check_eq("empty", empty_o, occ == 0);
        check_eq("full", full_o, occ == DEP);
        check_eq("almost_full", almost_full_o, occ >= AFT);
        check_eq("mem_we", mem_we_o, push_fire);
        if (push_fire) begin
            check_eq("mem_waddr", mem_waddr_o, wcnt % DEP);
            check_eq("mem_wdata", mem_wdata_o, pd);
        end
        check_eq("mem_re", mem_re_o, exp_re);
        if (exp_re) check_eq("mem_raddr", mem_raddr_o, exp_raddr);

        if (clr) begin
            model_reset();
        end else begin
            if (pop_fire) begin
                void'(exp_q.pop_front());
                void'(pc_q.pop_front());
                void'(idx_q.pop_front());
                last_pop = t;
            end
            if (push_fire) begin
                exp_q.push_back(pd);
                pc_q.push_back(t);
                idx_q.push_back(wcnt % DEP);
                wcnt++;
            end
        end
        accepted = push_fire;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n, input logic pr);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, pr, 1'b0, acc);
    endtask

    // Holds push_valid until the word is taken; a stuck FIFO is reported, not waited on.
    task automatic push_word(input logic [DW-1:0] d, input logic pr);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 50) begin
            step(1'b1, d, pr, 1'b0, acc);
            k++;
        end
        n_vec++;
        if (!acc) begin
            n_err++;
            $display("FAIL push_timeout: word 0x%0h got no ready within 50 cycles, wanted accept", d);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_pop_valid", pop_valid_o, 1'b0);
        check_eq("rst_push_ready", push_ready_o, 1'b1);
        check_eq("rst_empty", empty_o, 1'b1);
        check_eq("rst_full", full_o, 1'b0);
        check_eq("rst_almost_full", almost_full_o, 1'b0);
        check_eq("rst_occupancy", occupancy_o, '0);
        check_eq("rst_mem_re", mem_re_o, 1'b0);
        check_eq("rst_mem_we", mem_we_o, 1'b0);
    endtask

    initial begin
        logic acc;
        int   sent;
        n_vec = 0;
        n_err = 0;
        t     = 0;
        model_reset();

        // Reset, with a push request pending that must not reach the SCM
        push_valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        push_valid_i = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;

        // Single word: write at 0, fetch at 1, head at 2, empty at 3
        step(1'b1, 32'hA5, 1'b1, 1'b0, acc);
        idle(4, 1'b1);

        // Fill to full with backpressure, head held stable for 10 cycles
        for (int i = 1; i <= 4; i++) push_word(i, 1'b0);
        idle(10, 1'b0);
        // Push while full with a pop in the same cycle: refused then, taken next cycle
        push_word(5, 1'b1);
        idle(8, 1'b1);

        // Streaming at one word per cycle with pointer wrap
        for (int i = 0; i < 20; i++) push_word(i, 1'b1);
        idle(6, 1'b1);

        // Random traffic with random backpressure
        sent = 0;
        for (int c = 0; c < 3000 && sent < 200; c++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0), 1'b0, acc);
            if (acc) sent++;
        end
        n_vec++;
        if (sent != 200) begin
            n_err++;
            $display("FAIL random_push_count: pushed %0d words, wanted 200", sent);
        end
        idle(10, 1'b1);

        // Clear with three entries and a valid head, then restart at slot 0
        for (int i = 0; i < 3; i++) push_word(32'hC0 + i, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 32'hDEAD, 1'b1, 1'b1, acc);
        push_word(32'h77, 1'b0);
        idle(4, 1'b1);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 3; i++) push_word(32'h100 + i, 1'b0);
        idle(2, 1'b0);
        push_valid_i = 1'b1;
        pop_ready_i  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        push_valid_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        t++;
        for (int i = 0; i < 6; i++) push_word($urandom, 1'($urandom_range(0, 1)));
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_fifo_scm_ctrl.md
Name: hwpe_stream_fifo_scm_ctrl

Overview:
- FIFO controller that sequences one latch-based SCM macro (2**ADDR_WIDTH words, 1-cycle registered read, write data sampled at clk then latched) into a valid/ready stream FIFO.
- Owns the write pointer, read pointer, occupancy and head-of-queue FSM; drives the SCM's ReadEnable/ReadAddr/WriteEnable/WriteAddr/WriteData.
- Sits between a producer stream and a consumer stream inside hwpe-stream FIFO wrappers.

Parameters:
ADDR_WIDTH, 5, SCM address width; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 32, word width
ALMOST_FULL_TH, 2**ADDR_WIDTH-2, occupancy at or above which almost_full_o asserts

Ports:
clk  in  1  clock (single domain)
rst_n  in  1  asynchronous active-low reset
clear_i  in  1  synchronous flush
push_valid_i  in  1  producer valid
push_ready_o  out  1  producer ready
push_data_i  in  DATA_WIDTH  producer data
pop_valid_o  out  1  consumer valid
pop_ready_i  in  1  consumer ready
pop_data_o  out  DATA_WIDTH  consumer data (= mem_rdata_i)
mem_re_o  out  1  SCM ReadEnable
mem_raddr_o  out  ADDR_WIDTH  SCM ReadAddr
mem_rdata_i  in  DATA_WIDTH  SCM ReadData
mem_we_o  out  1  SCM WriteEnable
mem_waddr_o  out  ADDR_WIDTH  SCM WriteAddr
mem_wdata_o  out  DATA_WIDTH  SCM WriteData
occupancy_o  out  ADDR_WIDTH+1  entries written and not yet popped
empty_o  out  1  occupancy_o == 0
full_o  out  1  occupancy_o == DEPTH
almost_full_o  out  1  occupancy_o >= ALMOST_FULL_TH

Behaviour:
- Reset (rst_n low, asynchronous): wptr=0, rptr=0, occ=0, FSM=NO_HEAD.
  - Resulting outputs: pop_valid_o=0, push_ready_o=1, empty_o=1, full_o=0, almost_full_o=0, occupancy_o=0.
  - mem_re_o=0 and mem_we_o=0 while reset is asserted.
  - Reset mid-operation discards all entries. SCM contents are don't-care.
- Registers: wptr, rptr (ADDR_WIDTH, wrap modulo DEPTH naturally), occ (ADDR_WIDTH+1), 1-bit FSM.
- Push:
  - push_ready_o = (occ < DEPTH) & ~clear_i. It depends only on registered occ; there is no combinational path from pop_ready_i.
  - push fire = push_valid_i & push_ready_o.
  - mem_we_o = fire; mem_waddr_o = wptr; mem_wdata_o = push_data_i.
  - On fire, wptr++.
- Write visibility: a word written in cycle N may be read-addressed no earlier than cycle N+1. The registered occ guarantees this.
- fetchable = occ - (FSM==HEAD). This counts entries in the SCM not yet presented at the head.
- FSM NO_HEAD (pop_valid_o=0):
  - If fetchable>0: mem_re_o=1, mem_raddr_o=rptr, rptr++, go to HEAD.
  - Else stay.
- FSM HEAD (pop_valid_o=1):
  - pop_data_o comes from the SCM word at the last fetched address.
  - That word is never overwritten while presented, because occ still counts it.
  - Pop fire (pop_ready_i=1): occ decrements.
    - If fetchable>0: mem_re_o=1, mem_raddr_o=rptr, rptr++, stay HEAD (back-to-back, 1 pop/cycle).
    - Else go to NO_HEAD.
  - No pop fire: hold; mem_re_o=0, so the SCM address register holds the data stable.
- occ update each cycle: occ + push_fire - pop_fire. Simultaneous push and pop leaves occ unchanged.
- Full boundary: when occ==DEPTH, push is refused even if a pop fires in the same cycle. Push is accepted the next cycle.
- Latency:
  - Push in cycle N into an empty FIFO: fetch in N+1, pop_valid_o=1 in N+2.
  - Steady-state throughput is 1 word/cycle in each direction.
- clear_i (synchronous, priority over everything):
  - mem_we_o=0, mem_re_o=0, push_ready_o=0 in that cycle.
  - Next cycle: wptr=rptr=occ=0, FSM=NO_HEAD.
- Flags are combinational from occ only. empty_o is occupancy-based, so it may be 0 while pop_valid_o is still 0 during the fetch cycle.
- pop_valid_o, once high, stays high with stable pop_data_o until pop_ready_i (stream protocol).

Test Plan:
- Setup: ADDR_WIDTH=2 (DEPTH 4), ALMOST_FULL_TH=2, controller wired to the SCM.
- Reset then single push 0xA5 at cycle 0, pop_ready_i=1 -> mem_we_o=1/mem_waddr_o=0 at cycle 0; mem_re_o=1/mem_raddr_o=0 at cycle 1; pop_valid_o=1 with 0xA5 at cycle 2; empty_o=1 at cycle 3.
- Fill with 1,2,3,4, pop_ready_i=0 -> full_o=1, occupancy_o=4, push_ready_o=0; pop_valid_o=1 with data 1 held stable for 10 cycles.
- Full, push_valid_i=1 and pop fires at the same cycle -> push refused that cycle, accepted next; output order 1,2,3,4,5 with wrap (waddr 0 reused).
- Continuous push 0..19 and pop_ready_i=1 -> one pop/cycle after the 2-cycle startup; in-order output 0..19, occupancy_o constant, pointers wrap 5 times.
- Random pop_ready_i backpressure, 200 words -> no loss/duplication; almost_full_o iff occupancy_o>=2.
- clear_i with occ=3 and head valid -> next cycle pop_valid_o=0, occupancy_o=0, waddr 0.
- rst_n pulse mid-stream -> outputs immediately at reset values.
